ka_mul_seq: RTL

- Parametrised, sequential, one-level Karatsuba carry-less multiplier over GF(2)[x] with operand width W.
- A single combinational half-width carry-less core is time-multiplexed over three cycles for the products lo·lo, hi·hi and (lo^hi)·(lo^hi).
- The three partial products are combined with the XOR/overlap rule.
- It is the area-reduced successor to the fixed-width, fully combinational KA stages and feeds binary-field arithmetic units through valid/ready handshakes.

---
 rtl/ka_pkg.sv | 38 +++
 rtl/ka_mul_seq_clmul_core.sv | 30 +++
 rtl/ka_mul_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ka_pkg.sv
// Shared types and helpers for the sequential Karatsuba carry-less multiplier.
// gf2_reduce is only called when KA_REDUCE_EN is defined.
package ka_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        MID  = 3'd3,
        COMB = 3'd4,
        RED  = 3'd5,
        DONE = 3'd6
    } state_t;

    // Widest vector gf2_reduce handles; supports W up to 64.
    localparam int KA_RED_MAX = 128;

    function automatic int clmul_width(input int n);
        return 2 * n - 1;
    endfunction

    // Folds bits 2w-2 down to w back into the field using poly (which includes x^w).
    function automatic logic [KA_RED_MAX-1:0] gf2_reduce(
        input logic [KA_RED_MAX-1:0] v,
        input logic [KA_RED_MAX-1:0] poly,
        input int                    w
    );
        logic [KA_RED_MAX-1:0] r;
        r = v;
        for (int i = KA_RED_MAX - 1; i >= 0; i--) begin
            if (i >= w && i <= 2 * w - 2 && r[i]) begin
                r = r ^ (poly << (i - w));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ka_mul_seq_clmul_core.sv
// Combinational schoolbook carry-less multiplier, N x N -> 2N-1 bits.
module clmul_core
    import ka_pkg::*;
#(
    parameter int N = 13
) (
    input  logic [N-1:0]              i_a,
    input  logic [N-1:0]              i_b,
    output logic [clmul_width(N)-1:0] o_p
);

    localparam int PW = clmul_width(N);

    logic [PW-1:0] w_pp [N];
    logic [PW-1:0] w_acc;

    for (genvar i = 0; i < N; i++) begin : g_row
        assign w_pp[i] = i_b[i] ? (PW'(i_a) << i) : '0;
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N; i++) begin
            w_acc = w_acc ^ w_pp[i];
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/ka_mul_seq.sv
// Sequential one-level Karatsuba carry-less multiplier sharing one half-width core.
// Define KA_REDUCE_EN to add a RED state that reduces the product modulo POLY.
module ka_mul_seq
    import ka_pkg::*;
#(
    parameter int         W    = 26,
    parameter logic [W:0] POLY = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] y,
    output logic           busy,
    output state_t         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid and y hold steady until out_ready completes the transfer.

    localparam int N  = (W + 1) / 2;
    localparam int PW = clmul_width(N);
    localparam int YW = 2 * W - 1;

    state_t          r_state;
    logic [N-1:0]    r_a_lo, r_a_hi, r_b_lo, r_b_hi;
    logic [PW-1:0]   r_p_lo, r_p_hi, r_p_mid;
    logic [YW-1:0]   r_y;
    logic            r_in_ready, r_out_valid, r_busy;

    logic [N-1:0]    w_a_hi, w_b_hi;
    logic [N-1:0]    w_core_a, w_core_b;
    logic [PW-1:0]   w_core_p;
    logic [PW-1:0]   w_mid_sum;
    logic [YW-1:0]   w_y_full;

    // For odd W the high half is one bit narrower; zero-extend it to N.
    assign w_a_hi = N'(a[W-1:N]);
    assign w_b_hi = N'(b[W-1:N]);

    always_comb begin
        w_core_a = r_a_lo;
        w_core_b = r_b_lo;
        case (r_state)
            HI: begin
                w_core_a = r_a_hi;
                w_core_b = r_b_hi;
            end
            MID: begin
                w_core_a = r_a_lo ^ r_a_hi;
                w_core_b = r_b_lo ^ r_b_hi;
            end
            default: ;
        endcase
    end

    clmul_core #(.N(N)) u_core (
        .i_a (w_core_a),
        .i_b (w_core_b),
        .o_p (w_core_p)
    );

    // Shifts are done in the output width, so overflow bits (always zero) drop out.
    assign w_mid_sum = r_p_lo ^ r_p_hi ^ r_p_mid;
    assign w_y_full  = YW'(r_p_lo) ^ (YW'(w_mid_sum) << N) ^ (YW'(r_p_hi) << (2 * N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_lo      <= '0;
            r_a_hi      <= '0;
            r_b_lo      <= '0;
            r_b_hi      <= '0;
            r_p_lo      <= '0;
            r_p_hi      <= '0;
            r_p_mid     <= '0;
            r_y         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_lo     <= a[N-1:0];
                        r_a_hi     <= w_a_hi;
                        r_b_lo     <= b[N-1:0];
                        r_b_hi     <= w_b_hi;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= LO;
                    end
                end
                LO: begin
                    r_p_lo  <= w_core_p;
                    r_state <= HI;
                end
                HI: begin
                    r_p_hi  <= w_core_p;
                    r_state <= MID;
                end
                MID: begin
                    r_p_mid <= w_core_p;
                    r_state <= COMB;
                end
                COMB: begin
                    r_y <= w_y_full;
`ifdef KA_REDUCE_EN
                    r_state <= RED;
`else
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
`endif
                end
`ifdef KA_REDUCE_EN
                RED: begin
                    r_y         <= YW'(gf2_reduce(KA_RED_MAX'(r_y), KA_RED_MAX'(POLY), W));
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
